// File: rtl/cpu_pkg.sv
// Shared CPU constants and the instruction-memory loader state encoding.
package cpu_pkg;

    localparam int IMEM_ADDR_W = 5;
    localparam int IMEM_DEPTH  = 32;
    localparam int INSTR_W     = 32;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_COLLECT = 3'd1,
        ST_WRITE   = 3'd2,
        ST_CHECK   = 3'd3,
        ST_DONE    = 3'd4
    } ld_state_e;

endpackage

// File: rtl/byte_packer.sv
// Packs four bytes MSB-first into a 32-bit word; word_vld_o pulses combinationally
// on the 4th accepted byte, and word_o holds the full word from the following cycle.
module byte_packer (
    input  logic        clk,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        byte_vld_i,
    input  logic [7:0]  byte_dat_i,
    output logic        word_vld_o,
    output logic [31:0] word_o
);

    logic [1:0]  cnt_q, cnt_d;
    logic [31:0] sr_q, sr_d;

    always_comb begin
        cnt_d = cnt_q;
        sr_d  = sr_q;
        if (clr_i) begin
            cnt_d = 2'd0;
        end else if (byte_vld_i) begin
            sr_d  = {sr_q[23:0], byte_dat_i};
            cnt_d = cnt_q + 2'd1;
        end
    end

    assign word_vld_o = byte_vld_i && !clr_i && (cnt_q == 2'd3);
    assign word_o     = sr_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= 2'd0;
            sr_q  <= 32'd0;
        end else begin
            cnt_q <= cnt_d;
            sr_q  <= sr_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Streams bytes into instruction memory as big-endian words at addresses 0.., holding the CPU meanwhile.
// Optional trailing XOR checksum byte when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
    import cpu_pkg::*;
#(
    parameter int ADDR_W = IMEM_ADDR_W,
    parameter int DATA_W = INSTR_W,
    parameter int DEPTH  = IMEM_DEPTH
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_W:0]   load_words,
    input  logic              byte_valid,
    input  logic [7:0]        byte_data,
    output logic              byte_ready,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [DATA_W-1:0] wr_data,
    output logic              busy,
    output logic              cpu_hold,
    output logic              done,
    output logic [ADDR_W:0]   word_count,
    output logic              chk_err
);

    localparam logic [ADDR_W:0] DEPTH_W = (ADDR_W+1)'(DEPTH);

    ld_state_e         state_q, state_d;
    logic [ADDR_W:0]   lw_q, lw_d;
    logic [ADDR_W:0]   wc_q, wc_d;
    logic [ADDR_W:0]   wc_inc;
    logic              start_ok;
    logic              byte_fire;
    logic              word_vld;
    logic [DATA_W-1:0] word;

    assign start_ok  = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign byte_fire = byte_valid && byte_ready;
    assign wc_inc    = wc_q + 1'b1;

    byte_packer u_packer (
        .clk        (clk),
        .rst        (rst),
        .clr_i      (start_ok),
        .byte_vld_i (byte_fire && (state_q == ST_COLLECT)),
        .byte_dat_i (byte_data),
        .word_vld_o (word_vld),
        .word_o     (word)
    );

    always_comb begin
        state_d = state_q;
        lw_d    = lw_q;
        wc_d    = wc_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start_ok) begin
                    lw_d    = (load_words > DEPTH_W) ? DEPTH_W : load_words;
                    wc_d    = '0;
                    state_d = (load_words == '0) ? ST_DONE : ST_COLLECT;
                end
            end
            ST_COLLECT: begin
                if (word_vld) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                wc_d = wc_inc;
                if (wc_inc == lw_q) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    state_d = ST_CHECK;
`else
                    state_d = ST_DONE;
`endif
                end else begin
                    state_d = ST_COLLECT;
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (byte_fire) state_d = ST_DONE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lw_q    <= '0;
            wc_q    <= '0;
        end else begin
            state_q <= state_d;
            lw_q    <= lw_d;
            wc_q    <= wc_d;
        end
    end

`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0] xor_q, xor_d;
    logic       chk_q, chk_d;

    always_comb begin
        xor_d = xor_q;
        chk_d = chk_q;
        if (start_ok) begin
            xor_d = 8'd0;
            chk_d = 1'b0;
        end else if (byte_fire && (state_q == ST_COLLECT)) begin
            xor_d = xor_q ^ byte_data;
        end else if (byte_fire && (state_q == ST_CHECK)) begin
            chk_d = (byte_data != xor_q);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            xor_q <= 8'd0;
            chk_q <= 1'b0;
        end else begin
            xor_q <= xor_d;
            chk_q <= chk_d;
        end
    end

    assign chk_err = chk_q;
`else
    assign chk_err = 1'b0;
`endif

    // wr_data is gated so the port reads zero except during the write strobe
    assign byte_ready = (state_q == ST_COLLECT) || (state_q == ST_CHECK);
    assign wr_en      = (state_q == ST_WRITE);
    assign wr_addr    = wc_q[ADDR_W-1:0];
    assign wr_data    = wr_en ? word : '0;
    assign busy       = (state_q == ST_COLLECT) || (state_q == ST_WRITE) || (state_q == ST_CHECK);
    assign cpu_hold   = busy;
    assign done       = (state_q == ST_DONE);
    assign word_count = wc_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed self-checking bench for imem_loader; checksum steps run when IMEM_LOADER_CHECKSUM_EN is defined.
module tb_imem_loader;

    localparam int AW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          start;
    logic [AW:0]   load_words;
    logic          byte_valid;
    logic [7:0]    byte_data;
    logic          byte_ready;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [31:0]   wr_data;
    logic          busy;
    logic          cpu_hold;
    logic          done;
    logic [AW:0]   word_count;
    logic          chk_err;

    imem_loader dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .load_words (load_words),
        .byte_valid (byte_valid),
        .byte_data  (byte_data),
        .byte_ready (byte_ready),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .busy       (busy),
        .cpu_hold   (cpu_hold),
        .done       (done),
        .word_count (word_count),
        .chk_err    (chk_err)
    );

    always #5 clk = ~clk;

    int            checks = 0;
    int            failures = 0;
    logic [AW-1:0] log_addr[$];
    logic [31:0]   log_data[$];
    int            hold_drops = 0;
    bit            track_hold = 1'b0;
    logic [7:0]    run_xor = 8'd0;

    always @(negedge clk) begin
        if (wr_en) begin
            log_addr.push_back(wr_addr);
            log_data.push_back(wr_data);
        end
        if (track_hold && !cpu_hold) hold_drops++;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start(input logic [AW:0] n);
        start      = 1'b1;
        load_words = n;
        tick();
        start   = 1'b0;
        run_xor = 8'd0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int guard;
        repeat (gap) tick();
        byte_valid = 1'b1;
        byte_data  = b;
        guard = 0;
        while (!byte_ready && guard < 50) begin
            tick();
            guard++;
        end
        if (!byte_ready) check("byte_ready_timeout", 32'(byte_ready), 32'd1);
        tick();
        byte_valid = 1'b0;
        run_xor    = run_xor ^ b;
    endtask

    task automatic send_word(input logic [31:0] w, input int gap);
        send_byte(w[31:24], gap);
        send_byte(w[23:16], gap);
        send_byte(w[15:8],  gap);
        send_byte(w[7:0],   gap);
    endtask

    task automatic finish_load();
`ifdef IMEM_LOADER_CHECKSUM_EN
        send_byte(run_xor, 0);
`endif
    endtask

    task automatic wait_done(input string tag);
        int guard;
        guard = 0;
        while (!done && guard < 200) begin
            tick();
            guard++;
        end
        check(tag, 32'(done), 32'd1);
    endtask

    function automatic logic [31:0] gen_word(input int i);
        logic [7:0] b;
        b = 8'(i);
        return {b, 8'hA5, ~b, b + 8'h11};
    endfunction

    initial begin
        #500000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int          mism;
        int          n_before;
        logic [7:0]  gaps [8];
        logic [31:0] w;

        rst        = 1'b1;
        start      = 1'b0;
        load_words = '0;
        byte_valid = 1'b0;
        byte_data  = 8'd0;
        tick();
        tick();
        check("reset_ctrl", 32'({wr_en, busy, cpu_hold, done, byte_ready, chk_err, word_count, wr_addr}), 32'd0);
        check("reset_wr_data", wr_data, 32'd0);
        rst = 1'b0;
        tick();

        // Basic single-word load
        log_addr.delete(); log_data.delete();
        do_start(6'd1);
        check("t1_busy_after_start", 32'(busy), 32'd1);
        send_word(32'hE000_0007, 0);
        check("t1_wr_en_latency", 32'(wr_en), 32'd1);
        finish_load();
        wait_done("t1_done");
        check("t1_nwrites", 32'(log_addr.size()), 32'd1);
        check("t1_addr", 32'(log_addr[0]), 32'd0);
        check("t1_data", log_data[0], 32'hE000_0007);
        check("t1_word_count", 32'(word_count), 32'd1);
        check("t1_busy_hold", 32'({busy, cpu_hold}), 32'd0);
        check("t1_chk_err", 32'(chk_err), 32'd0);

        // Throttled two-word load
        gaps[0] = 8'd0; gaps[1] = 8'd3; gaps[2] = 8'd5; gaps[3] = 8'd1;
        gaps[4] = 8'd2; gaps[5] = 8'd0; gaps[6] = 8'd4; gaps[7] = 8'd5;
        log_addr.delete(); log_data.delete();
        hold_drops = 0;
        do_start(6'd2);
        track_hold = 1'b1;
        w = 32'h2001_0003;
        for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], int'(gaps[k]));
        w = 32'h2002_0003;
        for (int k = 0; k < 4; k++) send_byte(w[31-8*k -: 8], int'(gaps[k+4]));
        track_hold = 1'b0;
        finish_load();
        wait_done("t2_done");
        check("t2_nwrites", 32'(log_addr.size()), 32'd2);
        check("t2_addr0", 32'(log_addr[0]), 32'd0);
        check("t2_data0", log_data[0], 32'h2001_0003);
        check("t2_addr1", 32'(log_addr[1]), 32'd1);
        check("t2_data1", log_data[1], 32'h2002_0003);
        check("t2_hold_drops", 32'(hold_drops), 32'd0);

        // Full depth, then an over-range count that clamps to the same result
        for (int pass = 0; pass < 2; pass++) begin
            log_addr.delete(); log_data.delete();
            do_start((pass == 0) ? 6'd32 : 6'd40);
            for (int i = 0; i < 32; i++) send_word(gen_word(i + pass), 0);
            finish_load();
            wait_done("t3_done");
            repeat (5) tick();
            check("t3_nwrites", 32'(log_addr.size()), 32'd32);
            check("t3_last_addr", 32'(log_addr[log_addr.size()-1]), 32'd31);
            check("t3_word_count", 32'(word_count), 32'd32);
            mism = 0;
            for (int i = 0; i < log_addr.size(); i++) begin
                if (log_addr[i] !== AW'(i) || log_data[i] !== gen_word(i + pass)) mism++;
            end
            check("t3_mismatches", 32'(mism), 32'd0);
        end

        // Reset during the third word
        log_addr.delete(); log_data.delete();
        do_start(6'd4);
        send_word(32'h0102_0304, 0);
        send_word(32'h0506_0708, 0);
        send_byte(8'h09, 0);
        send_byte(8'h0A, 0);
        rst = 1'b1;
        tick();
        check("t4_rst_ctrl", 32'({wr_en, busy, cpu_hold, done, byte_ready, chk_err, word_count, wr_addr}), 32'd0);
        check("t4_rst_wr_data", wr_data, 32'd0);
        rst = 1'b0;
        repeat (4) tick();
        check("t4_nwrites_after_rst", 32'(log_addr.size()), 32'd2);
        do_start(6'd1);
        send_word(32'hCAFE_F00D, 0);
        finish_load();
        wait_done("t4_done");
        check("t4_nwrites", 32'(log_addr.size()), 32'd3);
        check("t4_addr", 32'(log_addr[2]), 32'd0);
        check("t4_data", log_data[2], 32'hCAFE_F00D);

        // Start while busy is ignored; zero-length load finishes immediately
        log_addr.delete(); log_data.delete();
        do_start(6'd2);
        send_word(32'h1122_3344, 0);
        send_byte(8'h55, 0);
        send_byte(8'h66, 0);
        start      = 1'b1;
        load_words = 6'd1;
        tick();
        start = 1'b0;
        check("t5_busy_start_ignored", 32'({busy, word_count}), 32'({1'b1, 6'd1}));
        send_byte(8'h77, 0);
        send_byte(8'h88, 0);
        finish_load();
        wait_done("t5_done");
        check("t5_nwrites", 32'(log_addr.size()), 32'd2);
        check("t5_addr1", 32'(log_addr[1]), 32'd1);
        check("t5_data1", log_data[1], 32'h5566_7788);
        check("t5_word_count", 32'(word_count), 32'd2);
        do_start(6'd0);
        check("t5_zero_done", 32'({done, busy, word_count}), 32'({1'b1, 1'b0, 6'd0}));
        repeat (3) tick();
        check("t5_zero_nwrites", 32'(log_addr.size()), 32'd2);
        check("t5_zero_chk_err", 32'(chk_err), 32'd0);

`ifdef IMEM_LOADER_CHECKSUM_EN
        // Trailing checksum byte: 12^34^56^78 = 08
        do_start(6'd1);
        send_word(32'h1234_5678, 0);
        send_byte(8'h08, 0);
        wait_done("t6_good_done");
        check("t6_good_chk_err", 32'(chk_err), 32'd0);
        do_start(6'd1);
        send_word(32'h1234_5678, 0);
        send_byte(8'h09, 0);
        wait_done("t6_bad_done");
        check("t6_bad_chk_err", 32'(chk_err), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction memory. Takes a byte stream (for example, from a UART receiver), packs each 4 bytes into a big-endian 32-bit instruction, and writes the words to consecutive addresses from 0 through the memory write port.
- Holds the CPU with `cpu_hold` while loading, so fetch never reads a half-loaded program.

Parameters:
- ADDR_W, 5, instruction memory address width.
- DATA_W, 32, instruction width. Fixed at 4 bytes; other values are unsupported.
- DEPTH, 32, number of words. Equals 2**ADDR_W.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- start  input  1  one-cycle pulse that begins a load; ignored unless the state is IDLE or DONE.
- load_words  input  ADDR_W+1  number of words to load; sampled when start is accepted; valid range 0..DEPTH.
- byte_valid  input  1  byte_data is valid.
- byte_data  input  8  stream byte.
- byte_ready  output  1  loader accepts a byte this cycle.
- wr_en  output  1  instruction memory write strobe.
- wr_addr  output  ADDR_W  write address.
- wr_data  output  DATA_W  write data.
- busy  output  1  load in progress.
- cpu_hold  output  1  stall request to fetch/PC; equals busy.
- done  output  1  level; last load completed.
- word_count  output  ADDR_W+1  words written in the current or last load.
- chk_err  output  1  checksum mismatch; see Optional Feature.

Behaviour:
- Reset values: all outputs are 0 and the state is IDLE. Memory contents are not touched.
- States: IDLE, COLLECT, WRITE, CHECK (macro only), DONE.
- A byte is transferred on a cycle where byte_valid && byte_ready. byte_ready is 1 only in COLLECT and CHECK.
- IDLE/DONE on start:
  - Latch load_words, clear word_count, clear done, clear chk_err.
  - If load_words == 0: go to DONE; done is 1 next cycle.
  - If load_words > DEPTH: clamp to DEPTH.
  - Otherwise: go to COLLECT.
- COLLECT:
  - Shift each accepted byte in MSB-first: the first byte becomes bits 31:24, the fourth byte becomes bits 7:0.
  - A 2-bit byte counter tracks position. When the 4th byte is accepted, go to WRITE.
  - Gaps in byte_valid are allowed with no limit on their length.
- WRITE: exactly one cycle.
  - wr_en = 1, wr_addr = word_count[ADDR_W-1:0], wr_data = the assembled word.
  - byte_ready = 0.
  - On the next edge, word_count increments.
  - If word_count+1 == latched load_words: go to DONE (or CHECK with the macro). Otherwise go back to COLLECT.
- Latency: wr_en asserts the cycle after the 4th byte is accepted.
- Address wrap: a load of DEPTH words ends at wr_addr = DEPTH-1. There is never a write to address 0 past the end.
- busy is 1 in COLLECT, WRITE and CHECK.
- DONE: done = 1 and is held until the next accepted start or rst.
- start while busy: ignored, with no effect on state or counters.
- rst mid-load: return to IDLE on the next edge. The partial word is discarded and no write is issued. Words already written remain in memory.
- wr_en is never asserted outside WRITE.

Optional Feature:
- Macro name: IMEM_LOADER_CHECKSUM_EN.
- When defined:
  - A running XOR is kept over all data bytes of the load.
  - After the last WRITE, the state goes to CHECK, which accepts exactly one trailing byte.
  - On entering DONE, chk_err = 1 if that byte differs from the running XOR; otherwise chk_err = 0.
  - For a load_words == 0 load, no checksum byte is expected.
- When undefined:
  - There is no CHECK state.
  - chk_err is tied to 0.
  - No extra byte is consumed.

Decomposition:
- Shared package `cpu_pkg`:
  - constants IMEM_ADDR_W = 5, IMEM_DEPTH = 32, INSTR_W = 32.
  - loader state enum typedef.
- One natural sub-module, `byte_packer`: takes bytes and emits a 32-bit word with a word_valid pulse, using the 2-bit byte counter and shift register. The FSM and address counter stay in imem_loader.

Test Plan:
1. Basic load: load_words = 1; bytes E0, 00, 00, 07 back-to-back → single wr_en pulse, wr_addr 0, wr_data 32'hE000_0007; done = 1, word_count = 1, busy = 0.
2. Throttled stream: load_words = 2; bytes 20,01,00,03,20,02,00,03 with 0–5 idle cycles between them → writes 32'h2001_0003 at address 0 and 32'h2002_0003 at address 1; exactly 2 wr_en pulses; cpu_hold high throughout the load.
3. Full depth: load_words = 32; incrementing words → last write at address 31; word_count = 32; no write after it; load_words = 40 behaves identically (clamped).
4. Reset mid-word: rst after 2 bytes of word 3 → no wr_en that cycle or after; all outputs 0; a fresh start of 1 word writes at address 0.
5. Start handling: start during COLLECT has no effect; start with load_words = 0 gives done next cycle and no writes.
6. Checksum (macro defined): bytes 12,34,56,78 then 08 → chk_err = 0; with trailing byte 09 instead → chk_err = 1. Both end with done = 1.
